cga_line_multiplier: RTL

- Parametrised successor to the fixed 2x CGA scandoubler. Sits after the pixel pusher in the CGA/Tandy video path.
- Captures each source line into a ping-pong line buffer, then replays it REPEAT times at REPEAT x the source pixel rate, with its own hsync and data-enable.
- Generalises pixel width, maximum line length and replication factor (2x/3x/4x), and tolerates irregular source line lengths.

---
 rtl/cga_line_multiplier.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cga_line_multiplier.sv
// Ping-pong line buffer that replays each captured source line REPEAT times at REPEAT x pixel rate.
// Optional dark-scanline mode for replicas 1..REPEAT-1 is enabled by defining CGA_LINE_MULTIPLIER_SCANLINE_EN.
module cga_line_multiplier #(
    parameter int PIXEL_W  = 4,
    parameter int MAX_LINE = 1024,
    parameter int REPEAT   = 2,
    parameter int OUT_DIV  = 2,
    parameter int HSYNC_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_ce,
    input  logic               line_reset,
    input  logic [PIXEL_W-1:0] in_video,
`ifdef CGA_LINE_MULTIPLIER_SCANLINE_EN
    input  logic               scanlines,
`endif
    output logic [PIXEL_W-1:0] out_video,
    output logic               out_hsync,
    output logic               out_de,
    output logic [1:0]         out_rep
);

    localparam int AW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int LW    = $clog2(MAX_LINE + 1);
    localparam int DW    = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
    localparam int DEPTH = 2 * (1 << AW);

    localparam logic [DW-1:0] DIV_LAST  = DW'(OUT_DIV - 1);
    localparam logic [1:0]    REP_LAST  = 2'(REPEAT - 1);
    localparam logic [31:0]   HSYNC_LIM = 32'(HSYNC_W);
    localparam logic [LW-1:0] LINE_MAX  = LW'(MAX_LINE);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [PIXEL_W-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [LW-1:0] wr_x_q, wr_x_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [LW-1:0] line_len_q, line_len_d;
    logic [AW-1:0] rd_x_q, rd_x_d;
    logic [1:0]    rep_q, rep_d;
    logic [DW-1:0] div_q, div_d;

    logic [PIXEL_W-1:0] out_video_q;
    logic               out_hsync_q, out_hsync_d;
    logic               out_de_q, out_de_d;
    logic [1:0]         out_rep_q, out_rep_d;

    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_addr;
    logic          wr_full;
    logic          tick;
    logic          last_px;
    logic          active;
    logic          show;

    always_comb begin
        wr_full = (wr_x_q == LINE_MAX);
        tick    = (div_q == DIV_LAST);
        last_px = (LW'(rd_x_q) == (line_len_q - LW'(1)));
        active  = (state_q == ACTIVE);
        rd_addr = {rd_bank_q, rd_x_q};

        // A coincident line_reset steers the pixel to slot 0 of the bank that is about to become the write bank.
        wr_en   = 1'b0;
        wr_addr = {wr_bank_q, wr_x_q[AW-1:0]};
        if (line_reset) begin
            wr_en   = in_ce;
            wr_addr = {~wr_bank_q, {AW{1'b0}}};
        end else if (in_ce && !wr_full) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_x_d     = wr_x_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        line_len_d = line_len_q;
        rd_x_d     = rd_x_q;
        rep_d      = rep_q;
        div_d      = div_q;

        if (line_reset) begin
            line_len_d = wr_x_q;
            rd_bank_d  = wr_bank_q;
            wr_bank_d  = ~wr_bank_q;
            rd_x_d     = '0;
            rep_d      = '0;
            div_d      = '0;
            state_d    = (wr_x_q != '0) ? ACTIVE : IDLE;
            wr_x_d     = in_ce ? LW'(1) : '0;
        end else begin
            if (in_ce && !wr_full) begin
                wr_x_d = wr_x_q + LW'(1);
            end
            if (active) begin
                div_d = tick ? '0 : div_q + DW'(1);
                if (tick) begin
                    if (last_px) begin
                        rd_x_d = '0;
                        if (rep_q == REP_LAST) begin
                            state_d = IDLE;
                        end else begin
                            rep_d = rep_q + 2'd1;
                        end
                    end else begin
                        rd_x_d = rd_x_q + AW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        out_de_d    = active;
        out_hsync_d = active && (32'(rd_x_q) < HSYNC_LIM);
        out_rep_d   = active ? rep_q : out_rep_q;
`ifdef CGA_LINE_MULTIPLIER_SCANLINE_EN
        show        = active && !(scanlines && (rep_q != 2'd0));
`else
        show        = active;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_x_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            line_len_q  <= '0;
            rd_x_q      <= '0;
            rep_q       <= '0;
            div_q       <= '0;
            out_hsync_q <= 1'b0;
            out_de_q    <= 1'b0;
            out_rep_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_x_q      <= wr_x_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            line_len_q  <= line_len_d;
            rd_x_q      <= rd_x_d;
            rep_q       <= rep_d;
            div_q       <= div_d;
            out_hsync_q <= out_hsync_d;
            out_de_q    <= out_de_d;
            out_rep_q   <= out_rep_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_video;
        end
    end

    // Synchronous RAM read whose output register doubles as the blanking point for IDLE and dark scanlines.
    always_ff @(posedge clk) begin
        if (reset || !show) begin
            out_video_q <= '0;
        end else begin
            out_video_q <= mem[rd_addr];
        end
    end

    assign out_video = out_video_q;
    assign out_hsync = out_hsync_q;
    assign out_de    = out_de_q;
    assign out_rep   = out_rep_q;

endmodule
